// File: rtl/divmod2_pkg.sv
// divmod2_pkg: shared FSM state type and default sizing for the divmod2 iteration controller.
package divmod2_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_WD_LIMIT = 15;

endpackage

// File: rtl/divmod2_acc.sv
// divmod2_acc: result accumulator holding remainder bits, popcount, bitlen and the step index.
module divmod2_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             cap_i,
    input  logic             mod2_i,
    output logic [WIDTH-1:0] bits_o,
    output logic [CNT_W-1:0] popcount_o,
    output logic [CNT_W-1:0] bitlen_o,
    output logic [CNT_W-1:0] iter_o
);

    logic [WIDTH-1:0] bits_q;
    logic [CNT_W-1:0] popcount_q, bitlen_q, iter_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            bits_q     <= '0;
            popcount_q <= '0;
            bitlen_q   <= '0;
            iter_q     <= '0;
        end else if (cap_i) begin
            bits_q     <= bits_q | (WIDTH'(mod2_i) << iter_q);
            popcount_q <= popcount_q + CNT_W'(mod2_i);
            iter_q     <= iter_q + 1'b1;
            bitlen_q   <= iter_q + 1'b1;
        end
    end

    assign bits_o     = bits_q;
    assign popcount_o = popcount_q;
    assign bitlen_o   = bitlen_q;
    assign iter_o     = iter_q;

endmodule

// File: rtl/divmod2_iter_ctrl.sv
// divmod2_iter_ctrl: drives a serial halving stage repeatedly to collect remainder bits of an operand.
// Optional watchdog on the WAIT state is enabled by defining DIVMOD2_WATCHDOG_EN.
module divmod2_iter_ctrl
    import divmod2_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WD_LIMIT = DEF_WD_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] popcount,
    output logic [CNT_W-1:0] bitlen,
    output logic             step_start,
    output logic [WIDTH-1:0] step_a,
    input  logic             step_valid,
    input  logic [WIDTH-1:0] step_div2,
    input  logic             step_mod2
);

    state_e           state_q;
    logic             busy_q, done_q, start_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] iter;
    logic             accept, cap, last;

    assign accept = (state_q == IDLE) && activate;
    assign cap    = (state_q == WAIT) && step_valid;
    assign last   = (step_div2 == '0) || (iter == CNT_W'(WIDTH - 1));

`ifdef DIVMOD2_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q, timeout;

    assign timeout = (state_q == WAIT) && !step_valid && (wd_q == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (state_q == WAIT) ? wd_q + 1'b1 : '0;
            err_q <= accept ? 1'b0 : (timeout ? 1'b1 : err_q);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            opnd_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (activate) begin
                    opnd_q <= a;
                    busy_q <= 1'b1;
                    if (a == '0) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (step_valid) begin
                    opnd_q <= step_div2;
                    if (last) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                    end
                end
`ifdef DIVMOD2_WATCHDOG_EN
                else if (timeout) begin
                    state_q <= FIN;
                    done_q  <= 1'b1;
                end
`endif
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    divmod2_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_acc (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (accept),
        .cap_i     (cap),
        .mod2_i    (step_mod2),
        .bits_o    (bits),
        .popcount_o(popcount),
        .bitlen_o  (bitlen),
        .iter_o    (iter)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign step_start = start_q;
    assign step_a     = opnd_q;

endmodule

// File: tb/tb_divmod2_iter_ctrl.sv
// tb_divmod2_iter_ctrl: table-driven check of the iteration controller against a latency-5 halving stage model.
module tb_divmod2_iter_ctrl;

    localparam int L = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       activate = 1'b0;
    logic [7:0] a = '0;
    logic       busy, done, err, step_start;
    logic [7:0] bits, step_a;
    logic [3:0] popcount, bitlen;
    logic       step_valid = 1'b0;
    logic [7:0] step_div2 = '0;
    logic       step_mod2 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    logic       stage_en = 1'b1;
    logic       force_valid = 1'b0;
    logic [7:0] issued[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] bits;
        int         pop;
        int         len;
        int         iters;
    } vec_t;
    vec_t vecs[7];

    divmod2_iter_ctrl dut (
        .clk(clk), .reset(reset), .activate(activate), .a(a),
        .busy(busy), .done(done), .err(err), .bits(bits),
        .popcount(popcount), .bitlen(bitlen),
        .step_start(step_start), .step_a(step_a),
        .step_valid(step_valid), .step_div2(step_div2), .step_mod2(step_mod2)
    );

    always #5 clk = ~clk;

    // Halving stage model: answers each step_start L cycles later with a>>1 and a[0].
    initial begin
        int         cnt;
        logic [7:0] op;
        cnt = 0;
        op  = '0;
        forever begin
            @(negedge clk);
            step_valid = force_valid;
            if (reset) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    step_valid = 1'b1;
                    step_div2  = op >> 1;
                    step_mod2  = op[0];
                end
            end else if (step_start && stage_en) begin
                op  = step_a;
                cnt = L;
                issued.push_back(step_a);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [7:0] av, input int limit, output int cyc);
        issued.delete();
        activate = 1'b1;
        a = av;
        @(negedge clk);
        activate = 1'b0;
        cyc = 1;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_bits"}, bits, 0);
        chk({nm, "_pop"}, popcount, 0);
        chk({nm, "_len"}, bitlen, 0);
        chk({nm, "_start"}, step_start, 0);
        chk({nm, "_step_a"}, step_a, 0);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [7:0] exp_a[8];
        vecs[0] = '{8'h00, 8'h00, 0, 0, 0};
        vecs[1] = '{8'hB5, 8'hB5, 5, 8, 8};
        vecs[2] = '{8'h40, 8'h40, 1, 7, 7};
        vecs[3] = '{8'h01, 8'h01, 1, 1, 1};
        vecs[4] = '{8'h03, 8'h03, 2, 2, 2};
        vecs[5] = '{8'hFF, 8'hFF, 8, 8, 8};
        vecs[6] = '{8'h80, 8'h80, 1, 8, 8};
        exp_a = '{8'hB5, 8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01};

        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].a, 200, cyc);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_bits", i), bits, vecs[i].bits);
            chk($sformatf("v%0d_pop", i), popcount, vecs[i].pop);
            chk($sformatf("v%0d_len", i), bitlen, vecs[i].len);
            chk($sformatf("v%0d_err", i), err, 0);
            chk($sformatf("v%0d_iters", i), issued.size(), vecs[i].iters);
            if (vecs[i].a == 8'h00) chk("zero_latency", cyc <= 2, 1);
            if (vecs[i].a == 8'hB5 && issued.size() == 8)
                for (int k = 0; k < 8; k++) chk($sformatf("b5_step_a%0d", k), issued[k], exp_a[k]);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
            chk($sformatf("v%0d_hold_bits", i), bits, vecs[i].bits);
        end

        // activate during WAIT is dropped, stray step_valid in IDLE is ignored
        issued.delete();
        activate = 1'b1;
        a = 8'hB5;
        @(negedge clk);
        activate = 1'b0;
        repeat (3) @(negedge clk);
        activate = 1'b1;
        a = 8'hFF;
        @(negedge clk);
        activate = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_done", done, 1);
        chk("ign_bits", bits, 8'hB5);
        chk("ign_pop", popcount, 5);
        chk("ign_len", bitlen, 8);
        @(negedge clk);
        force_valid = 1'b1;
        step_div2 = 8'h00;
        step_mod2 = 1'b1;
        @(negedge clk);
        force_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_bits", bits, 8'hB5);
        chk("stray_pop", popcount, 5);
        chk("stray_len", bitlen, 8);

        // reset while waiting on the stage aborts without a done pulse
        activate = 1'b1;
        a = 8'hB5;
        @(negedge clk);
        activate = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle_zero("abort");
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        run(8'h03, 200, cyc);
        chk("post_rst_done", done, 1);
        chk("post_rst_pop", popcount, 2);
        chk("post_rst_len", bitlen, 2);
        chk("post_rst_bits", bits, 8'h03);
        @(negedge clk);

        // stage never answers
        stage_en = 1'b0;
`ifdef DIVMOD2_WATCHDOG_EN
        run(8'h80, 100, cyc);
        chk("wd_done", done, 1);
        chk("wd_err", err, 1);
        chk("wd_len", bitlen, 0);
        chk("wd_latency", cyc, 17);
        @(negedge clk);
        chk("wd_idle", busy, 0);
        stage_en = 1'b1;
        run(8'h01, 200, cyc);
        chk("wd_clear_err", err, 0);
        chk("wd_clear_len", bitlen, 1);
`else
        run(8'h80, 60, cyc);
        chk("nowd_no_done", done, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_err", err, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stage_en = 1'b1;
        chk("nowd_reset_idle", busy, 0);
`endif
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
